// File: rtl/hazard_control.sv
// Hazard detection and stall/flush control for the five-stage MIPS pipeline (load-use and ID-branch operands).
// Optional performance counters (StallCycles, FlushCount) are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] IFIDRs,
  input  logic [4:0] IFIDRt,
  input  logic       IFID_UsesRs,
  input  logic       IFID_UsesRt,
  input  logic       IFID_Branch,
  input  logic       IFID_Jump,
  input  logic       BranchTaken,
  input  logic [4:0] IDEXRd,
  input  logic       IDEX_RW,
  input  logic       IDEX_MemRead,
  input  logic [4:0] EXMEMRd,
  input  logic       EXMEM_MemRead,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IDEXBubble,
  output logic       IFIDFlush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
`endif
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t     state;
  logic [1:0] cnt;

  logic       ex_hit;
  logic       mem_hit;
  logic [1:0] need;
  logic       stall;

  // Register $0 is hardwired to zero, so a dependency on it is never real.
  assign ex_hit  = (IFID_UsesRs && (IFIDRs != 5'd0) && (IFIDRs == IDEXRd)) ||
                   (IFID_UsesRt && (IFIDRt != 5'd0) && (IFIDRt == IDEXRd));
  assign mem_hit = (IFID_UsesRs && (IFIDRs != 5'd0) && (IFIDRs == EXMEMRd)) ||
                   (IFID_UsesRt && (IFIDRt != 5'd0) && (IFIDRt == EXMEMRd));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    need = 2'd0;
    if (IFID_Branch && IDEX_MemRead && ex_hit)
      need = 2'd2;
    else if (IFID_Branch && IDEX_RW && ex_hit)
      need = 2'd1;
    else if (IFID_Branch && EXMEM_MemRead && mem_hit)
      need = 2'd1;
    else if (!IFID_Branch && IDEX_MemRead && ex_hit)
      need = 2'd1;
  end

  assign stall = !reset && ((state == HOLD) || (need != 2'd0));

  // Stall dominates flush: a branch outcome is not trusted while its operands are pending.
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXBubble = 1'b0;
    IFIDFlush  = 1'b0;
    if (stall) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end else if (!reset) begin
      IFIDFlush = (IFID_Branch && BranchTaken) || IFID_Jump;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (need == 2'd2) begin
            state <= HOLD;
            cnt   <= 2'd1;
          end
        end
        HOLD: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1)
            state <= RUN;
        end
        default: begin
          state <= RUN;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCycles <= 32'd0;
      FlushCount  <= 32'd0;
    end else begin
      if (stall)
        StallCycles <= StallCycles + 32'd1;
      if (IFIDFlush)
        FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Directed self-checking bench for hazard_control; inputs change on the falling edge, outputs checked 1 ns later.
module tb_hazard_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IFIDRs, IFIDRt, IDEXRd, EXMEMRd;
  logic       IFID_UsesRs, IFID_UsesRt, IFID_Branch, IFID_Jump, BranchTaken;
  logic       IDEX_RW, IDEX_MemRead, EXMEM_MemRead;
  logic       PCWrite, IFIDWrite, IDEXBubble, IFIDFlush;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCycles, FlushCount;
`endif

  int checks = 0;
  int fails  = 0;

  // {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush}
  localparam logic [3:0] RUN_O   = 4'b1100;
  localparam logic [3:0] FLUSH_O = 4'b1101;
  localparam logic [3:0] STALL_O = 4'b0010;

  always #5 clk = ~clk;

  hazard_control dut (
    .clk(clk), .reset(reset),
    .IFIDRs(IFIDRs), .IFIDRt(IFIDRt),
    .IFID_UsesRs(IFID_UsesRs), .IFID_UsesRt(IFID_UsesRt),
    .IFID_Branch(IFID_Branch), .IFID_Jump(IFID_Jump), .BranchTaken(BranchTaken),
    .IDEXRd(IDEXRd), .IDEX_RW(IDEX_RW), .IDEX_MemRead(IDEX_MemRead),
    .EXMEMRd(EXMEMRd), .EXMEM_MemRead(EXMEM_MemRead),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble), .IFIDFlush(IFIDFlush)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCycles(StallCycles), .FlushCount(FlushCount)
`endif
  );

  function automatic logic [3:0] outs();
    return {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush};
  endfunction

  task automatic idle();
    IFIDRs = 5'd0; IFIDRt = 5'd0; IDEXRd = 5'd0; EXMEMRd = 5'd0;
    IFID_UsesRs = 1'b0; IFID_UsesRt = 1'b0; IFID_Branch = 1'b0; IFID_Jump = 1'b0;
    BranchTaken = 1'b0; IDEX_RW = 1'b0; IDEX_MemRead = 1'b0; EXMEM_MemRead = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    IDEX_MemRead = 1'b1; IDEXRd = 5'd8; IFIDRs = 5'd8; IFID_UsesRs = 1'b1;
    #1;
    checks++;
    if (outs() !== RUN_O) begin fails++; $display("FAIL reset_loaduse got=%b exp=%b", outs(), RUN_O); end
    idle();
    IFID_Jump = 1'b1;
    #1;
    checks++;
    if (outs() !== RUN_O) begin fails++; $display("FAIL reset_jump got=%b exp=%b", outs(), RUN_O); end
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    IDEX_MemRead = 1'b1; IDEXRd = 5'd8; IFIDRs = 5'd8; IFID_UsesRs = 1'b1;
    #1;
    checks++;
    if (outs() !== STALL_O) begin fails++; $display("FAIL loaduse_stall got=%b exp=%b", outs(), STALL_O); end
    tick();
    IDEX_MemRead = 1'b0;
    #1;
    checks++;
    if (outs() !== RUN_O) begin fails++; $display("FAIL loaduse_release got=%b exp=%b", outs(), RUN_O); end
    tick();
    idle();
    IDEX_MemRead = 1'b1; IDEXRd = 5'd17; IFIDRt = 5'd17; IFID_UsesRt = 1'b1;
    #1;
    checks++;
    if (outs() !== STALL_O) begin fails++; $display("FAIL loaduse_rt got=%b exp=%b", outs(), STALL_O); end
    tick();
    idle();
  endtask

  task automatic test_branch_after_load();
    IFID_Branch = 1'b1; BranchTaken = 1'b1;
    IDEX_MemRead = 1'b1; IDEXRd = 5'd9; IFIDRt = 5'd9; IFID_UsesRt = 1'b1;
    #1;
    checks++;
    if (outs() !== STALL_O) begin fails++; $display("FAIL brload_c1 got=%b exp=%b", outs(), STALL_O); end
    tick();
    // Detection inputs now clean: only the HOLD state can keep the stall.
    IDEX_MemRead = 1'b0; IDEXRd = 5'd0;
    #1;
    checks++;
    if (outs() !== STALL_O) begin fails++; $display("FAIL brload_c2_hold got=%b exp=%b", outs(), STALL_O); end
    tick();
    #1;
    checks++;
    if (outs() !== FLUSH_O) begin fails++; $display("FAIL brload_c3_flush got=%b exp=%b", outs(), FLUSH_O); end
    tick();
    BranchTaken = 1'b0;
    #1;
    checks++;
    if (outs() !== RUN_O) begin fails++; $display("FAIL branch_not_taken got=%b exp=%b", outs(), RUN_O); end
    tick();
    idle();
  endtask

  task automatic test_branch_after_alu();
    IFID_Branch = 1'b1; BranchTaken = 1'b1;
    IDEX_RW = 1'b1; IDEXRd = 5'd10; IFIDRs = 5'd10; IFID_UsesRs = 1'b1;
    #1;
    checks++;
    if (outs() !== STALL_O) begin fails++; $display("FAIL bralu_stall got=%b exp=%b", outs(), STALL_O); end
    tick();
    IDEXRd = 5'd3;
    #1;
    checks++;
    if (outs() !== FLUSH_O) begin fails++; $display("FAIL bralu_resolve got=%b exp=%b", outs(), FLUSH_O); end
    tick();
    idle();
    IFID_Branch = 1'b1; EXMEM_MemRead = 1'b1; EXMEMRd = 5'd11; IFIDRs = 5'd11; IFID_UsesRs = 1'b1;
    #1;
    checks++;
    if (outs() !== STALL_O) begin fails++; $display("FAIL br_memload got=%b exp=%b", outs(), STALL_O); end
    tick();
    EXMEM_MemRead = 1'b0;
    #1;
    checks++;
    if (outs() !== RUN_O) begin fails++; $display("FAIL br_memload_release got=%b exp=%b", outs(), RUN_O); end
    tick();
    idle();
  endtask

  task automatic test_no_hazard();
    IDEX_MemRead = 1'b1; IDEXRd = 5'd0; IFIDRs = 5'd0; IFID_UsesRs = 1'b1;
    #1;
    checks++;
    if (outs() !== RUN_O) begin fails++; $display("FAIL reg0_load got=%b exp=%b", outs(), RUN_O); end
    idle();
    IDEX_MemRead = 1'b1; IDEXRd = 5'd8; IFIDRt = 5'd8; IFID_UsesRt = 1'b0;
    #1;
    checks++;
    if (outs() !== RUN_O) begin fails++; $display("FAIL unused_rt got=%b exp=%b", outs(), RUN_O); end
    idle();
    IDEX_RW = 1'b1; IDEXRd = 5'd12; IFIDRs = 5'd12; IFID_UsesRs = 1'b1;
    #1;
    checks++;
    if (outs() !== RUN_O) begin fails++; $display("FAIL alu_forwarded got=%b exp=%b", outs(), RUN_O); end
    idle();
    EXMEM_MemRead = 1'b1; EXMEMRd = 5'd13; IFIDRs = 5'd13; IFID_UsesRs = 1'b1;
    #1;
    checks++;
    if (outs() !== RUN_O) begin fails++; $display("FAIL memload_forwarded got=%b exp=%b", outs(), RUN_O); end
    idle();
    IFID_Branch = 1'b1; IDEX_MemRead = 1'b1; IDEXRd = 5'd0; IFIDRs = 5'd0; IFID_UsesRs = 1'b1;
    #1;
    checks++;
    if (outs() !== RUN_O) begin fails++; $display("FAIL branch_reg0 got=%b exp=%b", outs(), RUN_O); end
    tick();
    idle();
  endtask

  task automatic test_jump();
    IFID_Jump = 1'b1;
    #1;
    checks++;
    if (outs() !== FLUSH_O) begin fails++; $display("FAIL jump_flush got=%b exp=%b", outs(), FLUSH_O); end
    tick();
    idle();
  endtask

  task automatic test_reset_in_hold();
    IFID_Branch = 1'b1; IDEX_MemRead = 1'b1; IDEXRd = 5'd14; IFIDRs = 5'd14; IFID_UsesRs = 1'b1;
    #1;
    checks++;
    if (outs() !== STALL_O) begin fails++; $display("FAIL rsthold_enter got=%b exp=%b", outs(), STALL_O); end
    tick();
    idle();
    reset = 1'b1;
    #1;
    checks++;
    if (outs() !== RUN_O) begin fails++; $display("FAIL rsthold_forced got=%b exp=%b", outs(), RUN_O); end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (outs() !== RUN_O) begin fails++; $display("FAIL rsthold_run got=%b exp=%b", outs(), RUN_O); end
    tick();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_counters();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    IDEX_MemRead = 1'b1; IDEXRd = 5'd8; IFIDRs = 5'd8; IFID_UsesRs = 1'b1;
    tick();
    idle();
    tick();
    IFID_Branch = 1'b1; BranchTaken = 1'b1;
    IDEX_MemRead = 1'b1; IDEXRd = 5'd9; IFIDRt = 5'd9; IFID_UsesRt = 1'b1;
    tick();
    IDEX_MemRead = 1'b0; IDEXRd = 5'd0;
    tick();
    tick();
    idle();
    #1;
    checks++;
    if (StallCycles !== 32'd3) begin fails++; $display("FAIL perf_stalls got=%0d exp=3", StallCycles); end
    checks++;
    if (FlushCount !== 32'd1) begin fails++; $display("FAIL perf_flushes got=%0d exp=1", FlushCount); end
    tick();
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle();
    tick();
    test_reset();
    test_load_use();
    test_branch_after_load();
    test_branch_after_alu();
    test_no_hazard();
    test_jump();
    test_reset_in_hold();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
